// File: rtl/l15_port_arbiter_pkg.sv
// Shared types and defaults for the L1.5 port arbiter slice.
package l15_port_arbiter_pkg;

    // Arbiter control states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT_IF  = 2'd1,
        GRANT_MEM = 2'd2,
        WAIT_RESP = 2'd3
    } arb_state_t;

    // Requester identities.
    typedef enum logic {
        REQ_IF  = 1'b0,
        REQ_MEM = 1'b1
    } req_id_t;

    // Consecutive data-memory grants tolerated while fetch is waiting.
    localparam int STARVE_MAX_DEFAULT = 4;

    // Arbitration decision: data side wins unless fetch has been starved.
    function automatic arb_state_t arb_pick(input logic if_val,
                                            input logic mem_val,
                                            input logic starved);
        if (if_val && starved)
            return GRANT_IF;
        else if (mem_val)
            return GRANT_MEM;
        else if (if_val)
            return GRANT_IF;
        else
            return IDLE;
    endfunction

endpackage

// File: rtl/l15_starve_counter.sv
// Saturating count of data-memory grants taken while fetch waits.
module l15_starve_counter
    import l15_port_arbiter_pkg::*;
#(
    parameter int MAX = STARVE_MAX_DEFAULT,
    parameter int CW  = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          inc,
    input  logic          clr,
    output logic          sat,
    output logic [CW-1:0] cnt
);

    assign sat = (cnt == CW'(MAX));

    // Count up on inc, hold at MAX, clear has priority.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !sat)
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/l15_port_arbiter.sv
// Arbitrates the fetch and data-memory requesters onto a single L1.5 port,
// keeping at most one request outstanding and steering the response back.
module l15_port_arbiter
    import l15_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        nrst,

    // fetch requester
    input  logic [4:0]  if_l15_rqtype,
    input  logic [2:0]  if_l15_size,
    input  logic [31:0] if_l15_address,
    input  logic [31:0] if_l15_data,
    input  logic        if_l15_val,
    output logic        l15_if_ack,
    output logic        l15_if_header_ack,
    output logic        l15_if_val,
    input  logic        if_l15_req_ack,

    // data-memory requester
    input  logic [4:0]  mem_l15_rqtype,
    input  logic [2:0]  mem_l15_size,
    input  logic [31:0] mem_l15_address,
    input  logic [31:0] mem_l15_data,
    input  logic        mem_l15_val,
    output logic        l15_mem_ack,
    output logic        l15_mem_header_ack,
    output logic        l15_mem_val,
    input  logic        mem_l15_req_ack,

    // shared L1.5 port
    output logic [4:0]  transducer_l15_rqtype,
    output logic [2:0]  transducer_l15_size,
    output logic [31:0] transducer_l15_address,
    output logic [31:0] transducer_l15_data,
    output logic        transducer_l15_val,
    input  logic        l15_transducer_ack,
    input  logic        l15_transducer_header_ack,
    input  logic        l15_transducer_val,
    input  logic [63:0] l15_transducer_data_0,
    input  logic [63:0] l15_transducer_data_1,
    input  logic [3:0]  l15_transducer_returntype,
    output logic        transducer_l15_req_ack,

    // response broadcast
    output logic [63:0] l15_resp_data_0,
    output logic [63:0] l15_resp_data_1,
    output logic [3:0]  l15_resp_returntype,
    output logic        grant_mem
);

    arb_state_t state, state_next;
    req_id_t    resp_owner, resp_owner_next;

    logic       starved;
    logic       starve_inc;
    logic       starve_clr;
    logic       arb_en;
    logic       complete;
    logic       owner_req_ack;
    arb_state_t pick;

    l15_starve_counter #(.MAX(STARVE_MAX)) u_starve (
        .clk  (clk),
        .nrst (nrst),
        .inc  (starve_inc),
        .clr  (starve_clr),
        .sat  (starved),
        .cnt  ()
    );

    // Responses are broadcast unregistered; only the *_val strobes are steered.
    assign l15_resp_data_0     = l15_transducer_data_0;
    assign l15_resp_data_1     = l15_transducer_data_1;
    assign l15_resp_returntype = l15_transducer_returntype;

    assign grant_mem = (state == GRANT_MEM) ||
                       (state == WAIT_RESP && resp_owner == REQ_MEM);

    // Next-state, starvation bookkeeping and port steering.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next             = state;
        resp_owner_next        = resp_owner;
        transducer_l15_rqtype  = '0;
        transducer_l15_size    = '0;
        transducer_l15_address = '0;
        transducer_l15_data    = '0;
        transducer_l15_val     = 1'b0;
        l15_if_ack             = 1'b0;
        l15_if_header_ack      = 1'b0;
        l15_mem_ack            = 1'b0;
        l15_mem_header_ack     = 1'b0;
        l15_if_val             = 1'b0;
        l15_mem_val            = 1'b0;
        transducer_l15_req_ack = 1'b0;

        owner_req_ack = (resp_owner == REQ_MEM) ? mem_l15_req_ack : if_l15_req_ack;
        complete      = (state == WAIT_RESP) && l15_transducer_val && owner_req_ack;
        arb_en        = (state == IDLE) || complete;
        pick          = arb_pick(if_l15_val, mem_l15_val, starved);

        unique case (state)
            IDLE: begin
                state_next = pick;
            end
            GRANT_IF: begin
                transducer_l15_rqtype  = if_l15_rqtype;
                transducer_l15_size    = if_l15_size;
                transducer_l15_address = if_l15_address;
                transducer_l15_data    = if_l15_data;
                transducer_l15_val     = if_l15_val;
                l15_if_ack             = if_l15_val && l15_transducer_ack;
                l15_if_header_ack      = if_l15_val && l15_transducer_header_ack;
                if (!if_l15_val) begin
                    state_next = IDLE;
                end else if (l15_transducer_ack) begin
                    state_next      = WAIT_RESP;
                    resp_owner_next = REQ_IF;
                end
            end
            GRANT_MEM: begin
                transducer_l15_rqtype  = mem_l15_rqtype;
                transducer_l15_size    = mem_l15_size;
                transducer_l15_address = mem_l15_address;
                transducer_l15_data    = mem_l15_data;
                transducer_l15_val     = mem_l15_val;
                l15_mem_ack            = mem_l15_val && l15_transducer_ack;
                l15_mem_header_ack     = mem_l15_val && l15_transducer_header_ack;
                if (!mem_l15_val) begin
                    state_next = IDLE;
                end else if (l15_transducer_ack) begin
                    state_next      = WAIT_RESP;
                    resp_owner_next = REQ_MEM;
                end
            end
            WAIT_RESP: begin
                l15_if_val             = (resp_owner == REQ_IF)  && l15_transducer_val;
                l15_mem_val            = (resp_owner == REQ_MEM) && l15_transducer_val;
                transducer_l15_req_ack = owner_req_ack;
                if (complete)
                    state_next = pick;
            end
            default: state_next = IDLE;
        endcase

        starve_inc = arb_en && (pick == GRANT_MEM) && if_l15_val;
        starve_clr = (arb_en && (pick == GRANT_IF)) || !if_l15_val;
    end

    // State and response-owner registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            resp_owner <= REQ_IF;
        end else begin
            state      <= state_next;
            resp_owner <= resp_owner_next;
        end
    end

endmodule

// File: doc/l15_port_arbiter.md
L15_PORT_ARBITER -- requirements
Module: l15_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: number of consecutive data-memory grants allowed while fetch waits.
REQ-002 SHALL have port clk, in, 1: clock.
REQ-003 SHALL have port nrst, in, 1: reset, asynchronous, active-low.
REQ-004 SHALL have ports if_l15_rqtype/size/address/data, in, 5/3/32/32: fetch request fields.
REQ-005 SHALL have port if_l15_val, in, 1: fetch request valid.
REQ-006 SHALL have ports l15_if_ack/header_ack, out, 1 each: fetch request accepted.
REQ-007 SHALL have ports l15_if_val, out, 1 and if_l15_req_ack, in, 1: fetch response valid and its consumption.
REQ-008 SHALL have ports mem_l15_rqtype/size/address/data, in, 5/3/32/32: data-memory request fields.
REQ-009 SHALL have port mem_l15_val, in, 1: data request valid.
REQ-010 SHALL have ports l15_mem_ack/header_ack, out, 1 each: data request accepted.
REQ-011 SHALL have ports l15_mem_val, out, 1 and mem_l15_req_ack, in, 1: data response valid and its consumption.
REQ-012 SHALL have ports transducer_l15_rqtype/size/address/data/val, out, 5/3/32/32/1: shared request to L1.5.
REQ-013 SHALL have ports l15_transducer_ack/header_ack, in, 1 each: L1.5 request acceptance.
REQ-014 SHALL have ports l15_transducer_val, in, 1 and l15_transducer_data_0/1, in, 64 each: L1.5 response.
REQ-015 SHALL have port l15_transducer_returntype, in, 4: response type.
REQ-016 SHALL have port transducer_l15_req_ack, out, 1: response consumed.
REQ-017 SHALL have ports l15_resp_data_0/1, out, 64, and l15_resp_returntype, out, 4: response broadcast to both requesters.
REQ-018 SHALL have port grant_mem, out, 1: 1 = data side owns the port.

Function
REQ-019 SHALL implement states IDLE, GRANT_IF, GRANT_MEM, WAIT_RESP.
REQ-020 In IDLE with any valid, SHALL register a grant and enter GRANT_IF/GRANT_MEM the next cycle. Arbitration latency is 1 cycle.
REQ-021 Priority SHALL be: mem over fetch, except fetch wins when starve_cnt == STARVE_MAX.
REQ-022 starve_cnt SHALL increment on each mem grant while if_l15_val=1, saturate at STARVE_MAX, and clear on a fetch grant or when if_l15_val=0.
REQ-023 In GRANT_x, the owner's request fields/val SHALL drive transducer_l15_* combinationally. The non-owner SHALL see ack=header_ack=0. transducer_l15_val=0 in IDLE/WAIT_RESP.
REQ-024 On l15_transducer_ack=1 in GRANT_x, SHALL route the ack to the owner only, record the owner in resp_owner, and enter WAIT_RESP.
REQ-025 In WAIT_RESP, l15_transducer_val SHALL be routed only to resp_owner's *_val. transducer_l15_req_ack SHALL equal resp_owner's req_ack.
REQ-026 Completion is l15_transducer_val & owner req_ack in the same cycle. On completion SHALL arbitrate directly (same rules as IDLE) and enter GRANT_x next cycle, or IDLE if no valid.
REQ-027 At most one request SHALL be outstanding. Ownership SHALL never change while outstanding.
REQ-028 If the owner drops val before ack in GRANT_x, SHALL return to IDLE next cycle with no ack issued.
REQ-029 l15_transducer_val outside WAIT_RESP SHALL be ignored: no *_val asserted, transducer_l15_req_ack=0.
REQ-030 Response data/returntype SHALL pass through unregistered to l15_resp_*.

Reset
REQ-031 SHALL drive, during reset: state=IDLE, starve_cnt=0, resp_owner=fetch, grant_mem=0, all *_val/ack/header_ack outputs 0, transducer_l15_req_ack=0.
REQ-032 Reset asserted mid-transaction SHALL abandon the outstanding request with no response forwarded. The first cycle after deassertion SHALL behave as IDLE.

Structure
REQ-033 A shared package SHALL hold the state enum, the requester-id enum (REQ_IF, REQ_MEM) and the STARVE_MAX default.
REQ-034 Starvation counting SHALL be a sub-module l15_starve_counter: inputs inc, clr; output sat.

Verification
REQ-035 Fetch only, addr 0x100: val@c0 -> GRANT_IF@c1, ack@c2 -> WAIT_RESP. Response data_0=0xDEAD -> only l15_if_val=1, grant_mem=0.
REQ-036 Both val in IDLE -> mem granted first. Fetch granted after mem completion. l15_mem_val never asserts for the fetch response.
REQ-037 Both continuously valid, STARVE_MAX=4 -> mem, mem, mem, mem, then fetch. starve_cnt clears to 0.
REQ-038 Completion and new mem val in the same cycle -> GRANT_MEM next cycle with no IDLE cycle.
REQ-039 nrst low during WAIT_RESP, then spurious l15_transducer_val after release -> all response valids 0, state IDLE.
REQ-040 Owner drops val before ack in GRANT_MEM -> IDLE next cycle, no l15_mem_ack pulse.
